// File: rtl/shape_pkg.sv
// shape_pkg: waveform and sequencer types shared by the oscillator bank
package shape_pkg;

    typedef enum logic [1:0] {SAWTOOTH, SQUARE, SIN, TRIANGLE} wave_shape;

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_SHAPE, ST_SCALE, ST_EMIT} osc_state;

    function automatic longint phase_scale(int phase_bits, int sample_rate);
        return ((longint'(1) << phase_bits) + longint'(sample_rate / 2)) / longint'(sample_rate);
    endfunction

endpackage

// File: rtl/osc_bank_if.sv
// osc_bank_if: control, sample stream and status signals of the oscillator bank
interface osc_bank_if #(
    parameter int WIDTH  = 24,
    parameter int VOICES = 8
);
    import shape_pkg::*;
    localparam int VW = VOICES > 1 ? $clog2(VOICES) : 1;
    logic            sample_tick;
    logic            cfg_we;
    logic [VW-1:0]   cfg_voice;
    logic [15:0]     cfg_freq;
    logic [WIDTH-1:0] cfg_amp;
    wave_shape       cfg_shape;
    logic            cfg_enable;
    logic            out_valid;
    logic            out_ready;
    logic [WIDTH-1:0] out_sample;
    logic [VW-1:0]   out_voice;
    logic            out_last;
    logic            busy;
    logic            tick_overrun;

    modport slave (
        input  sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_amp, cfg_shape, cfg_enable, out_ready,
        output out_valid, out_sample, out_voice, out_last, busy, tick_overrun
    );

    modport master (
        output sample_tick, cfg_we, cfg_voice, cfg_freq, cfg_amp, cfg_shape, cfg_enable, out_ready,
        input  out_valid, out_sample, out_voice, out_last, busy, tick_overrun
    );
endinterface

// File: rtl/osc_bank_sin_rom.sv
// sin_rom: offset-binary full-wave sine table, one-cycle registered read
module sin_rom #(
    parameter int    WIDTH    = 24,
    parameter int    LUT_BITS = 10,
    parameter string LUT_FILE = "../lookup_tables/sin_lut.txt"
) (
    input  logic                clk,
    input  logic [LUT_BITS-1:0] i_addr,
    output logic [WIDTH-1:0]    o_data
);
    localparam int DEPTH = 1 << LUT_BITS;

    // Table entries are built at elaboration; an empty LUT_FILE name gives a silent ROM
    function automatic logic [WIDTH-1:0] entry(int idx, bit en);
        real x, s, t, top;
        top = (2.0 ** WIDTH) - 1.0;
        x = 6.283185307179586 * idx / DEPTH;
        if (x > 3.141592653589793) x = x - 6.283185307179586;
        s = x;
        t = x;
        for (int k = 1; k < 12; k++) begin
            t = -t * x * x / ((2 * k) * (2 * k + 1));
            s = s + t;
        end
        s = s > 1.0 ? 1.0 : (s < -1.0 ? -1.0 : s);
        return en ? WIDTH'(longint'((s + 1.0) * top / 2.0)) : '0;
    endfunction

    logic [WIDTH-1:0] w_tab [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        localparam logic [WIDTH-1:0] VAL = entry(g, LUT_FILE != "");
        assign w_tab[g] = VAL;
    end

    // Registered read
    always_ff @(posedge clk) o_data <= w_tab[i_addr];
endmodule

// File: rtl/osc_bank.sv
// osc_bank: time-multiplexed oscillator bank emitting one sample per voice per tick
module osc_bank
    import shape_pkg::*;
#(
    parameter int     WIDTH       = 24,
    parameter int     VOICES      = 8,
    parameter int     PHASE_BITS  = 32,
    parameter int     LUT_BITS    = 10,
    parameter int     SAMPLE_RATE = 48000,
    parameter longint PHASE_SCALE = phase_scale(PHASE_BITS, SAMPLE_RATE),
    parameter string  LUT_FILE    = "../lookup_tables/sin_lut.txt"
) (
    input logic       clk,
    input logic       rst,
    osc_bank_if.slave bus
);
    localparam int VW = VOICES > 1 ? $clog2(VOICES) : 1;

    logic [15:0]           r_freq  [VOICES];
    logic [WIDTH-1:0]      r_amp   [VOICES];
    wave_shape             r_shape [VOICES];
    logic [PHASE_BITS-1:0] r_phase [VOICES];
    logic [VOICES-1:0]     r_en;
    osc_state              r_state, w_next;
    logic [VW-1:0]         r_voice;
    logic [WIDTH:0]        r_cur_top;
    logic [WIDTH-1:0]      r_cur_amp, r_raw, r_out_sample, w_raw, w_rom;
    wave_shape             r_cur_shape;
    logic                  r_cur_en, r_overrun, w_last, w_cfg_ok;
    logic [PHASE_BITS-1:0] w_inc;
    logic [2*WIDTH:0]      w_prod;

    assign w_last   = r_voice == VW'(VOICES - 1);
    assign w_cfg_ok = {1'b0, bus.cfg_voice} < (VW + 1)'(VOICES);
    assign w_inc    = PHASE_BITS'(longint'(r_freq[r_voice]) * PHASE_SCALE);
    assign w_prod   = (2*WIDTH+1)'(r_raw) * (2*WIDTH+1)'(r_cur_amp) + (2*WIDTH+1)'(r_raw);
    assign w_raw    = (r_cur_shape == SAWTOOTH) ? r_cur_top[WIDTH:1] :
                      (r_cur_shape == SQUARE)   ? {WIDTH{~r_cur_top[WIDTH]}} :
                      (r_cur_shape == SIN)      ? w_rom :
                                                  r_cur_top[WIDTH-1:0] ^ {WIDTH{r_cur_top[WIDTH]}};

    assign bus.out_valid    = r_state == ST_EMIT;
    assign bus.out_last     = r_state == ST_EMIT && w_last;
    assign bus.out_voice    = r_voice;
    assign bus.out_sample   = r_out_sample;
    assign bus.busy         = r_state != ST_IDLE;
    assign bus.tick_overrun = r_overrun;

    sin_rom #(.WIDTH(WIDTH), .LUT_BITS(LUT_BITS), .LUT_FILE(LUT_FILE)) u_rom (
        .clk    (clk),
        .i_addr (r_phase[r_voice][PHASE_BITS-1 -: LUT_BITS]),
        .o_data (w_rom)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;

    // Next state: one voice per FETCH..EMIT pass, frame ends after the last voice's handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = bus.sample_tick ? ST_FETCH : ST_IDLE;
            ST_FETCH: w_next = ST_SHAPE;
            ST_SHAPE: w_next = ST_SCALE;
            ST_SCALE: w_next = ST_EMIT;
            ST_EMIT:  w_next = !bus.out_ready ? ST_EMIT : (w_last ? ST_IDLE : ST_FETCH);
            default:  w_next = ST_IDLE;
        endcase
    end

    // Voice register file: phase advance in FETCH, config writes win over the advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_freq[i]  <= '0;
                r_amp[i]   <= '0;
                r_shape[i] <= SAWTOOTH;
                r_phase[i] <= '0;
            end
        end else begin
            if (r_state == ST_FETCH) r_phase[r_voice] <= r_en[r_voice] ? r_phase[r_voice] + w_inc : '0;
            if (bus.cfg_we && w_cfg_ok) begin
                r_freq[bus.cfg_voice]  <= bus.cfg_freq;
                r_amp[bus.cfg_voice]   <= bus.cfg_amp;
                r_shape[bus.cfg_voice] <= bus.cfg_shape;
                r_en[bus.cfg_voice]    <= bus.cfg_enable;
                if (!bus.cfg_enable) r_phase[bus.cfg_voice] <= '0;
            end
        end
    end

    // Shared datapath: latch voice, shape, scale, plus voice counter and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_voice      <= '0;
            r_cur_top    <= '0;
            r_cur_amp    <= '0;
            r_cur_shape  <= SAWTOOTH;
            r_cur_en     <= 1'b0;
            r_raw        <= '0;
            r_out_sample <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (bus.sample_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
            if (r_state == ST_IDLE) r_voice <= '0;
            else if (r_state == ST_EMIT && bus.out_ready && !w_last) r_voice <= r_voice + VW'(1);
            if (r_state == ST_FETCH) begin
                r_cur_top   <= r_phase[r_voice][PHASE_BITS-1 -: WIDTH+1];
                r_cur_amp   <= r_amp[r_voice];
                r_cur_shape <= r_shape[r_voice];
                r_cur_en    <= r_en[r_voice];
            end
            if (r_state == ST_SHAPE) r_raw <= w_raw;
            if (r_state == ST_SCALE) r_out_sample <= r_cur_en ? WIDTH'(w_prod >> WIDTH) : '0;
        end
    end
endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: scoreboard bench for the oscillator bank with four voices
module tb_osc_bank;
    import shape_pkg::*;

    typedef struct packed {
        logic [1:0]  voice;
        logic [23:0] sample;
        logic        last;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    osc_bank_if #(.WIDTH(24), .VOICES(4)) bus();

    osc_bank #(
        .WIDTH(24), .VOICES(4), .PHASE_BITS(32), .PHASE_SCALE(65536)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    smp_t q_exp[$];
    smp_t q_obs[$];
    int n_vec = 0;
    int n_err = 0;

    // Capture every accepted sample
    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready)
            q_obs.push_back({bus.out_voice, bus.out_sample, bus.out_last});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.sample_tick = 1'b0;
        bus.cfg_we = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic cfg(input int v, input logic [15:0] f, input logic [23:0] a, input wave_shape s, input logic en);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1;
        bus.cfg_voice = 2'(v);
        bus.cfg_freq = f;
        bus.cfg_amp = a;
        bus.cfg_shape = s;
        bus.cfg_enable = en;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
    endtask

    task automatic expect_frame(input logic [23:0] s0, s1, s2, s3);
        q_exp.push_back({2'd0, s0, 1'b0});
        q_exp.push_back({2'd1, s1, 1'b0});
        q_exp.push_back({2'd2, s2, 1'b0});
        q_exp.push_back({2'd3, s3, 1'b1});
    endtask

    task automatic wait_obs(input int n, input string what);
        int k = 0;
        while (q_obs.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (q_obs.size() < n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got %0d samples, want %0d", what, q_obs.size(), n);
            while (q_obs.size() < n) q_obs.push_back('1);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_frame(input logic [23:0] s0, s1, s2, s3);
        expect_frame(s0, s1, s2, s3);
        pulse_tick();
        wait_obs(q_exp.size(), "frame");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.tick_overrun, bus.out_voice, bus.out_sample} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b last=%b busy=%b ovr=%b voice=%0d sample=%h, want all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.tick_overrun, bus.out_voice, bus.out_sample);
        end
        do_reset();
    endtask

    task automatic test_timing();
        smp_t e, o;
        do_reset();
        expect_frame(0, 0, 0, 0);
        pulse_tick();
        n_vec++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL timing_busy_rise: got %b, want 1", bus.busy); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL timing_early_valid cycle %0d: got %b, want 0", i + 2, bus.out_valid); end
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL timing_first_valid: got %b, want 1 at cycle 4", bus.out_valid); end
        wait_obs(4, "timing");
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL timing_busy_fall: got %b, want 0", bus.busy); end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL timing: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    task automatic test_square();
        smp_t e, o;
        do_reset();
        cfg(0, 16'd16384, 24'hFFFFFF, SQUARE, 1'b1);
        for (int f = 0; f < 8; f++) run_frame((f % 4) < 2 ? 24'hFFFFFF : 24'h0, 0, 0, 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL square: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    task automatic test_saw_tri();
        smp_t e, o;
        logic [23:0] tri_exp [4] = '{24'h000000, 24'h800000, 24'hFFFFFF, 24'h7FFFFF};
        do_reset();
        cfg(1, 16'd16384, 24'hFFFFFF, SAWTOOTH, 1'b1);
        cfg(2, 16'd16384, 24'hFFFFFF, TRIANGLE, 1'b1);
        for (int f = 0; f < 4; f++) run_frame(0, 24'(f) * 24'h400000, tri_exp[f], 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL saw_tri: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    task automatic test_half();
        smp_t e, o;
        do_reset();
        cfg(1, 16'd16384, 24'h7FFFFF, SAWTOOTH, 1'b1);
        for (int f = 0; f < 4; f++) run_frame(0, 24'(f) * 24'h200000, 0, 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL half_amp: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    task automatic test_stall();
        smp_t e, o;
        int k;
        do_reset();
        cfg(2, 16'd16384, 24'hFFFFFF, SAWTOOTH, 1'b1);
        run_frame(0, 0, 0, 0);
        expect_frame(0, 0, 24'h400000, 0);
        pulse_tick();
        k = 0;
        while (!(bus.out_valid && bus.out_voice == 2'd2) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (k >= 100) begin n_err++; $display("FAIL stall_reach_voice2: got no voice 2, want voice 2 valid"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.sample_tick = (i == 3);
            n_vec++;
            if ({bus.out_valid, bus.out_voice, bus.out_sample, bus.out_last} !== {1'b1, 2'd2, 24'h400000, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got valid=%b v%0d %h last=%b, want valid=1 v2 400000 last=0",
                         i, bus.out_valid, bus.out_voice, bus.out_sample, bus.out_last);
            end
        end
        bus.sample_tick = 1'b0;
        bus.out_ready = 1'b1;
        wait_obs(q_exp.size(), "stall");
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL stall: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
        n_vec++;
        if (bus.tick_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag: got %b, want 1", bus.tick_overrun); end
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (q_obs.size() != 0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_tick_ignored: got %0d extra samples busy=%b, want 0 and 0", q_obs.size(), bus.busy);
        end
    endtask

    task automatic test_reenable();
        smp_t e, o;
        do_reset();
        cfg(0, 16'd16384, 24'hFFFFFF, SQUARE, 1'b1);
        run_frame(24'hFFFFFF, 0, 0, 0);
        run_frame(24'hFFFFFF, 0, 0, 0);
        run_frame(24'h000000, 0, 0, 0);
        cfg(0, 16'd16384, 24'hFFFFFF, SQUARE, 1'b0);
        run_frame(24'h000000, 0, 0, 0);
        cfg(0, 16'd16384, 24'hFFFFFF, SQUARE, 1'b1);
        run_frame(24'hFFFFFF, 0, 0, 0);
        run_frame(24'hFFFFFF, 0, 0, 0);
        run_frame(24'h000000, 0, 0, 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL reenable: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    task automatic test_reset_mid();
        smp_t e, o;
        int k;
        do_reset();
        cfg(1, 16'd16384, 24'hFFFFFF, SAWTOOTH, 1'b1);
        run_frame(0, 0, 0, 0);
        q_exp.push_back({2'd0, 24'd0, 1'b0});
        pulse_tick();
        k = 0;
        while (!(bus.out_valid && bus.out_voice == 2'd1) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (bus.out_sample !== 24'h400000) begin n_err++; $display("FAIL midreset_pre_sample: got %h, want 400000", bus.out_sample); end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.tick_overrun, bus.out_voice, bus.out_sample} !== 30'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got valid=%b last=%b busy=%b ovr=%b voice=%0d sample=%h, want all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.tick_overrun, bus.out_voice, bus.out_sample);
        end
        @(posedge clk); #1 rst = 1'b0;
        expect_frame(0, 0, 0, 0);
        pulse_tick();
        wait_obs(q_exp.size(), "midreset");
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL midreset: got v%0d %h last=%b, want v%0d %h last=%b", o.voice, o.sample, o.last, e.voice, e.sample, e.last); end
        end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = '0;
        bus.cfg_freq    = '0;
        bus.cfg_amp     = '0;
        bus.cfg_shape   = SAWTOOTH;
        bus.cfg_enable  = 1'b0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_timing();
        test_square();
        test_saw_tri();
        test_half();
        test_stall();
        test_reenable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/osc_bank.md
# osc_bank

Time-multiplexed, parametrised oscillator bank: `VOICES` independent voices, each with its own frequency, amplitude, shape and enable. All voices share one phase/shape/scale datapath and one sine ROM. On every `sample_tick` the bank emits one sample per voice, in voice order, over a valid/ready stream. It sits between the control/register interface and the voice mixer, and replaces the single-voice oscillator as the synth's tone source.

## Interface
- `WIDTH`, 24, sample and amplitude width (unsigned, offset-binary)
- `VOICES`, 8, number of voices (≥1)
- `PHASE_BITS`, 32, phase accumulator width
- `LUT_BITS`, 10, log2 of sine ROM depth
- `SAMPLE_RATE`, 48000, output sample rate in Hz
- `PHASE_SCALE`, round(2^PHASE_BITS / SAMPLE_RATE) = 89478, phase increment per Hz
- `LUT_FILE`, "../lookup_tables/sin_lut.txt", sine ROM init file
- `clk`  in  1  system clock (faster than sample rate)
- `rst`  in  1  reset: **asynchronous, active-high**
- `sample_tick`  in  1  one-cycle strobe, once per sample period
- `cfg_we`  in  1  config write strobe
- `cfg_voice`  in  $clog2(VOICES)  voice being written
- `cfg_freq`  in  16  frequency in Hz
- `cfg_amp`  in  WIDTH  amplitude
- `cfg_shape`  in  wave_shape  waveform
- `cfg_enable`  in  1  voice enable
- `out_valid`  out  1  sample available
- `out_ready`  in  1  downstream accepts
- `out_sample`  out  WIDTH  sample value
- `out_voice`  out  $clog2(VOICES)  voice index of `out_sample`
- `out_last`  out  1  marks the last voice of the frame
- `busy`  out  1  frame in progress
- `tick_overrun`  out  1  sticky: a tick arrived while busy

## Operation
- Per-voice register file holds config and phase. `cfg_we` writes freq, amp, shape and enable of `cfg_voice` at the clock edge. Writing `cfg_enable=0` also clears that voice's phase to 0. An out-of-range `cfg_voice` is ignored.
- FSM states:
  - IDLE: wait for `sample_tick`.
  - FETCH: latch the current voice's config and phase; issue ROM address.
  - SHAPE: compute `raw`.
  - SCALE: compute the sample.
  - EMIT: assert `out_valid`; hold until `out_ready`. On the handshake, go to FETCH for the next voice, or to IDLE after voice `VOICES-1`.
- Phase increment: `inc = cfg_freq * PHASE_SCALE`, truncated to PHASE_BITS. Phase wraps modulo 2^PHASE_BITS.
- The sample uses the phase *before* the increment. The increment is written back in FETCH.
- A disabled voice still emits, with sample 0, and its phase is held at 0. This keeps the frame length fixed at `VOICES`.
- Waveform `raw` (WIDTH bits), with `p` = phase:
  - SAWTOOTH: `p[P-1 -: WIDTH]`
  - SQUARE: all-ones if `p[P-1]==0`, else 0
  - SIN: `lut[p[P-1 -: LUT_BITS]]`
  - TRIANGLE: `p[P-2 -: WIDTH]`, bitwise inverted when `p[P-1]==1`
- Scaling: `out = (raw * (amp+1)) >> WIDTH`, using a 2·WIDTH+1-bit product. amp=0 gives 0; all-ones amp gives `raw` exactly.
- A config write landing after its voice's FETCH takes effect on the next frame.
- `sample_tick` while `busy`: the tick is ignored and `tick_overrun` is set. The flag is cleared only by `rst`.

## Timing
- Reset values:
  - All phases and configs 0 (voices disabled), state IDLE.
  - `out_valid`=0, `out_sample`=0, `out_voice`=0, `out_last`=0, `busy`=0, `tick_overrun`=0.
- `busy` rises the cycle after `sample_tick` and falls the cycle after the last handshake.
- The first `out_valid` of a frame occurs 4 cycles after `sample_tick`. Each further voice takes 4 cycles after the previous handshake.
- Minimum frame length is 4·VOICES cycles. Clock must satisfy `clk/SAMPLE_RATE ≥ 4·VOICES` plus stall margin.
- While `out_valid && !out_ready`, `out_sample`, `out_voice` and `out_last` are stable. `out_valid` never drops without a handshake.
- `rst` mid-frame: the outputs above go to their reset values immediately; the frame is abandoned.

## Structure
- `shape_pkg` is extended: `wave_shape` = {SAWTOOTH, SQUARE, SIN, TRIANGLE}. TRIANGLE replaces the unused SAMPLE_NAME.
- FSM state enum and the `PHASE_SCALE` default function also live in `shape_pkg`.
- Sub-module `sin_rom`: parameters `WIDTH`, `LUT_BITS`, `LUT_FILE`; 1-cycle registered read; offset-binary full-wave table.

## Test plan
All scenarios use bench overrides `PHASE_SCALE=65536`, `PHASE_BITS=32`, `WIDTH=24`, `VOICES=4`, `out_ready=1`, unless noted.
- Voice 0 SQUARE, freq 16384, amp FFFFFF; 8 ticks → voice-0 samples FFFFFF, FFFFFF, 0, 0, repeating.
- Voice 1 SAWTOOTH and voice 2 TRIANGLE, freq 16384, amp FFFFFF:
  - voice 1 → 000000, 400000, 800000, C00000
  - voice 2 → 000000, 800000, FFFFFF, 7FFFFF
  - each frame has `out_voice` 0..3 and `out_last` only on voice 3.
- Voice 1 SAWTOOTH, freq 16384, amp 7FFFFF → half-scale: 000000, 200000, 400000, 600000. Disabled voices emit 0 every frame.
- `out_ready` held low for 10 cycles at voice 2 → outputs stable throughout, no sample lost. A `sample_tick` pulsed during the stall sets `tick_overrun`; that frame still completes with 4 samples.
- Disable voice 0 mid-waveform, then re-enable it → its first sample after re-enable is raw(phase 0): FFFFFF for SQUARE.
- `rst` asserted during EMIT of voice 1 → all outputs at reset values in the same cycle. After release, the next tick produces a frame starting at voice 0, with all samples 0.
